// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3-512 input stage.
package sha3_pkg;

  localparam int unsigned RATE_BITS       = 576;
  localparam int unsigned WORD_BITS       = 64;
  localparam int unsigned WORDS_PER_BLOCK = 9;
  localparam int unsigned BYTES_PER_WORD  = 8;
  localparam int unsigned COUNT_BITS      = 4;

  localparam logic [7:0] DOMAIN_PAD = 8'h06;
  localparam logic [7:0] FINAL_PAD  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2,
    ST_FULL = 2'd3
  } state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Applies SHA3 padding to one 64-bit word: domain byte after the message
// bytes of the last word, and the final 0x80 bit on the ninth word of a block.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_BITS-1:0] in,
  input  logic [2:0]           byte_num,
  input  logic                 is_last,
  input  logic                 is_ninth,
  output logic [WORD_BITS-1:0] padded_c
);

  always_comb begin
    padded_c = in;
    if (is_last) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (i == 32'(byte_num)) begin
          padded_c[8*i +: 8] = DOMAIN_PAD;
        end else if (i > 32'(byte_num)) begin
          padded_c[8*i +: 8] = 8'h00;
        end
      end
    end
    // The final bit lands on top of whatever byte 7 already holds (0x86 case).
    if (is_ninth) begin
      padded_c[WORD_BITS-1 -: 8] = padded_c[WORD_BITS-1 -: 8] | FINAL_PAD;
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// Message word stream to 576-bit padded rate blocks, handed to f_permutation
// through out/out_ready/f_ack.
module sha3_padder
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [2:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);

  localparam logic [COUNT_BITS-1:0] LAST_SLOT = COUNT_BITS'(WORDS_PER_BLOCK - 1);

  state_t                 state;
  logic [COUNT_BITS-1:0]  count;
  logic                   final_flag;

  logic                   pad_mode_c;
  logic                   filling_c;
  logic                   accept_c;
  logic [WORD_BITS-1:0]   word_src_c;
  logic                   word_last_c;
  logic                   word_ninth_c;
  logic [WORD_BITS-1:0]   padded_c;

  // PAD feeds zero words; the slot-8 word of a padded block carries the final bit.
  always_comb begin
    pad_mode_c   = (state == ST_PAD);
    filling_c    = (state == ST_IDLE) || (state == ST_FILL);
    accept_c     = filling_c && in_ready && !buffer_full;
    word_src_c   = pad_mode_c ? '0 : in;
    word_last_c  = !pad_mode_c && is_last;
    word_ninth_c = (count == LAST_SLOT) && (pad_mode_c || is_last);
  end

  sha3_pad_word u_pad_word (
    .in       (word_src_c),
    .byte_num (byte_num),
    .is_last  (word_last_c),
    .is_ninth (word_ninth_c),
    .padded_c (padded_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      final_flag  <= 1'b0;
      out         <= '0;
      out_ready   <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FILL: begin
          if (accept_c) begin
            out   <= {out[RATE_BITS-WORD_BITS-1:0], padded_c};
            count <= count + COUNT_BITS'(1);
            if (count == LAST_SLOT) begin
              state       <= ST_FULL;
              final_flag  <= is_last;
              out_ready   <= 1'b1;
              buffer_full <= 1'b1;
            end else if (is_last) begin
              state       <= ST_PAD;
              final_flag  <= 1'b1;
              buffer_full <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end
        end

        ST_PAD: begin
          out   <= {out[RATE_BITS-WORD_BITS-1:0], padded_c};
          count <= count + COUNT_BITS'(1);
          if (count == LAST_SLOT) begin
            state     <= ST_FULL;
            out_ready <= 1'b1;
          end
        end

        ST_FULL: begin
          // Block consumed: clear and reopen; an input raised this cycle waits one more.
          if (f_ack) begin
            state       <= final_flag ? ST_IDLE : ST_FILL;
            final_flag  <= 1'b0;
            count       <= '0;
            out         <= '0;
            out_ready   <= 1'b0;
            buffer_full <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder with a block scoreboard built from a byte-level model.
module tb_sha3_padder;
  import sha3_pkg::*;

  logic         clk;
  logic         reset;
  logic [63:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [2:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int total;
  int bad;

  logic [63:0]  cur[$];
  logic [575:0] exp_q[$];
  logic [575:0] got_blk;

  sha3_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [575:0] blk, input int k);
    return blk[575-64*k -: 64];
  endfunction

  // Reference model: collects padded words, emits a packed block every nine.
  task automatic model_add(input logic [63:0] w, input logic last, input logic [2:0] bn);
    logic [63:0]  pw;
    logic [63:0]  t;
    logic [575:0] blk;
    if (last) begin
      pw = '0;
      for (int j = 0; j < 8; j++) begin
        if (j < int'(bn)) pw[8*j +: 8] = w[8*j +: 8];
        else if (j == int'(bn)) pw[8*j +: 8] = 8'h06;
      end
    end else begin
      pw = w;
    end
    cur.push_back(pw);
    if (last) while (cur.size() < 9) cur.push_back(64'h0);
    if (cur.size() == 9) begin
      if (last) begin
        t = cur[8];
        t[63:56] = t[63:56] | 8'h80;
        cur[8] = t;
      end
      blk = '0;
      for (int k = 0; k < 9; k++) blk[575-64*k -: 64] = cur[k];
      exp_q.push_back(blk);
      cur.delete();
    end
  endtask

  // Present a word and hold it until the DUT takes it; returns just after the accept edge.
  task automatic send_word(input logic [63:0] w, input logic last, input logic [2:0] bn);
    bit taken;
    int tries;
    in       = w;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    taken    = 1'b0;
    tries    = 0;
    while (!taken && tries < 40) begin
      taken = !buffer_full;
      tick();
      tries++;
    end
    in_ready = 1'b0;
    check_i("accept_in_time", int'(taken), 1);
    model_add(w, last, bn);
  endtask

  // Wait for a block, compare it against the scoreboard, hold, then acknowledge.
  task automatic wait_block(input int exp_lat, input int hold);
    int lat;
    logic [575:0] exp;
    lat = 0;
    while (!out_ready && lat < 40) begin
      tick();
      lat++;
    end
    check_i("ready_latency", lat, exp_lat);
    check_i("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    got_blk = out;
    check("block", got_blk, exp);
    check_w("full_busy", 64'(buffer_full), 64'd1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("block_stable", out, exp);
      check_w("hold_busy", 64'(buffer_full), 64'd1);
      check_w("hold_ready", 64'(out_ready), 64'd1);
    end
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check_w("ready_after_ack", 64'(out_ready), 64'd0);
    check("out_cleared", out, 576'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    in       = '0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = '0;
    f_ack    = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_out", out, 576'd0);
    check_w("reset_ready", 64'(out_ready), 64'd0);
    check_w("reset_busy", 64'(buffer_full), 64'd0);
    reset = 1'b1;
    tick();

    // Empty message
    send_word(64'h0, 1'b1, 3'd0);
    check_w("pad_busy", 64'(buffer_full), 64'd1);
    wait_block(8, 2);
    check_w("empty_w0", word_of(got_blk, 0), 64'h0000000000000006);
    check_w("empty_w8", word_of(got_blk, 8), 64'h8000000000000000);

    // Stray f_ack while idle
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check_w("stray_ack_ready", 64'(out_ready), 64'd0);
    check_w("stray_ack_busy", 64'(buffer_full), 64'd0);
    check("stray_ack_out", out, 576'd0);

    // Two-word message, stray f_ack between the words
    send_word(64'h0706050403020100, 1'b0, 3'd0);
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check_w("midfill_ack_ready", 64'(out_ready), 64'd0);
    check_w("midfill_word_kept", out[63:0], 64'h0706050403020100);
    send_word(64'hFFFFFFFFFF0A0908, 1'b1, 3'd3);
    wait_block(7, 0);
    check_w("two_w0", word_of(got_blk, 0), 64'h0706050403020100);
    check_w("two_w1", word_of(got_blk, 1), 64'h00000000060A0908);
    check_w("two_w8", word_of(got_blk, 8), 64'h8000000000000000);

    // Last word in slot 8 with byte_num 7: no PAD cycles
    for (int i = 0; i < 8; i++) send_word({$urandom(), $urandom()}, 1'b0, 3'd0);
    send_word(64'h00AABBCCDDEEFF11, 1'b1, 3'd7);
    wait_block(0, 1);
    check_w("ninth_last_w8", word_of(got_blk, 8), 64'h86AABBCCDDEEFF11);

    // Full block, then a last word held against the full buffer with f_ack delayed
    for (int i = 0; i < 9; i++) send_word({$urandom(), $urandom()}, 1'b0, 3'd0);
    in       = 64'h1234567890ABCDEF;
    is_last  = 1'b1;
    byte_num = 3'd0;
    in_ready = 1'b1;
    wait_block(0, 5);
    check_w("bubble_busy", 64'(buffer_full), 64'd0);
    tick();
    in_ready = 1'b0;
    model_add(64'h1234567890ABCDEF, 1'b1, 3'd0);
    wait_block(8, 0);
    check_w("held_w0", word_of(got_blk, 0), 64'h0000000000000006);
    check_w("held_w8", word_of(got_blk, 8), 64'h8000000000000000);
    check_w("back_to_idle", 64'(dut.state), 64'(ST_IDLE));

    // Reset in the middle of PAD discards the partial block
    send_word(64'h0, 1'b1, 3'd0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midpad_reset_out", out, 576'd0);
    check_w("midpad_reset_ready", 64'(out_ready), 64'd0);
    check_w("midpad_reset_busy", 64'(buffer_full), 64'd0);
    exp_q.delete();
    cur.delete();
    tick();
    reset = 1'b1;
    tick();
    send_word(64'h0, 1'b1, 3'd0);
    wait_block(8, 0);
    check_w("post_reset_w0", word_of(got_blk, 0), 64'h0000000000000006);
    check_i("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
